mux_rr_n: RTL and testbench

Parametrised N-channel arbitrating multiplexer with a registered, handshaked output. It is the sequential successor of the 4:1 select multiplexers. It adds a configurable channel count and data width, a per-channel request/acknowledge handshake, and a round-robin arbitration mode beside the fixed-select mode. It sits between several producers and one consumer, for example a shared output port or a bus master stage.

---
 rtl/mux_rr_n.sv | 72 +++++++
 tb/tb_mux_rr_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel fixed-select / round-robin arbitrating mux with a registered, handshaked output slot
// Ports: clk_in/rst_n_in clock and async active-low reset; req_in/d_in per-channel request and packed data;
// mode_in 0 = fixed select on sel_in, 1 = round-robin; ack_out one-hot accept strobe;
// y_out/grant_id_out/y_valid_out output slot, drained when y_ready_in is high.
module mux_rr_n #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [N_CH-1:0]   req_in,
    input  logic [N_CH*W-1:0] d_in,
    input  logic              mode_in,
    input  logic [SW-1:0]     sel_in,
    output logic [N_CH-1:0]   ack_out,
    output logic [W-1:0]      y_out,
    output logic [SW-1:0]     grant_id_out,
    output logic              y_valid_out,
    input  logic              y_ready_in
);
    logic [SW-1:0] last_q;
    logic [SW-1:0] gid;
    logic          hit;
    logic          grant;
    logic          slot_free;
    int            idx;

    assign slot_free = !y_valid_out | y_ready_in;

    // Round-robin walks from last_q+1 upward with wrap; an out-of-range sel_in matches no channel.
    always_comb begin
        hit = 1'b0;
        gid = '0;
        idx = 0;
        if (mode_in) begin
            for (int k = 1; k <= N_CH; k++) begin
                idx = int'(last_q) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!hit && req_in[idx]) begin
                    hit = 1'b1;
                    gid = SW'(idx);
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sel_in == SW'(i) && req_in[i]) begin
                    hit = 1'b1;
                    gid = SW'(i);
                end
            end
        end
        grant = hit & slot_free & rst_n_in;
        for (int i = 0; i < N_CH; i++) ack_out[i] = grant && gid == SW'(i);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_out        <= '0;
            grant_id_out <= '0;
            y_valid_out  <= 1'b0;
            last_q       <= SW'(N_CH - 1);
        end else if (grant) begin
            y_out        <= d_in[int'(gid)*W +: W];
            grant_id_out <= gid;
            y_valid_out  <= 1'b1;
            last_q       <= gid;
        end else if (y_ready_in) begin
            y_valid_out  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: table-driven check of mux_rr_n with a scoreboard on the output slot
module tb_mux_rr_n;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] d = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic        rdy = 1'b0;
    logic [3:0]  ack;
    logic [7:0]  y;
    logic [1:0]  gid;
    logic        vld;

    logic [2:0]  req3 = '0;
    logic [23:0] d3 = {8'h33, 8'h22, 8'h11};
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic        rdy3 = 1'b0;
    logic [2:0]  ack3;
    logic [7:0]  y3;
    logic [1:0]  gid3;
    logic        vld3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] ack;
        logic       vld;
    } vec_t;
    vec_t tbl[24];

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
    } item_t;
    item_t sb[$];

    mux_rr_n #(.N_CH(4), .W(8)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .d_in(d), .mode_in(mode),
        .sel_in(sel), .ack_out(ack), .y_out(y), .grant_id_out(gid),
        .y_valid_out(vld), .y_ready_in(rdy)
    );

    mux_rr_n #(.N_CH(3), .W(8)) dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .req_in(req3), .d_in(d3), .mode_in(mode3),
        .sel_in(sel3), .ack_out(ack3), .y_out(y3), .grant_id_out(gid3),
        .y_valid_out(vld3), .y_ready_in(rdy3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the slot against the oldest expected word; pop it when it is drained this cycle.
    task automatic sb_check();
        if (vld) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                chk("sb_y", {24'h0, y}, {24'h0, sb[0].data});
                chk("sb_gid", {30'h0, gid}, {30'h0, sb[0].id});
                if (rdy) void'(sb.pop_front());
            end
        end
    endtask

    task automatic sb_push(input logic [3:0] a);
        for (int i = 0; i < 4; i++)
            if (a[i]) sb.push_back('{data: d[i*8 +: 8], id: 2'(i)});
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[1]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1};
        tbl[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1};
        tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1};
        for (int i = 12; i < 17; i++)
            tbl[i] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[18] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1};
        tbl[19] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[20] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[21] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0};
        tbl[22] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1};
        tbl[23] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1};

        #12;
        chk("rst_vld", {31'h0, vld}, 0);
        chk("rst_y", {24'h0, y}, 0);
        chk("rst_gid", {30'h0, gid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[v]) begin
            mode = tbl[v].mode;
            sel  = tbl[v].sel;
            req  = tbl[v].req;
            rdy  = tbl[v].rdy;
            @(negedge clk);
            chk($sformatf("ack[%0d]", v), {28'h0, ack}, {28'h0, tbl[v].ack});
            sb_check();
            sb_push(tbl[v].ack);
            @(posedge clk);
            #1;
            chk($sformatf("vld[%0d]", v), {31'h0, vld}, {31'h0, tbl[v].vld});
        end

        // Asynchronous reset while FULL, then first round-robin grant goes to channel 0.
        mode = 1'b1;
        req  = 4'b1111;
        rdy  = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", {31'h0, vld}, 0);
        chk("arst_y", {24'h0, y}, 0);
        chk("arst_gid", {30'h0, gid}, 0);
        chk("arst_ack", {28'h0, ack}, 0);
        sb.delete();
        @(negedge clk);
        #1;
        chk("rst_hold_ack", {28'h0, ack}, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ack0", {28'h0, ack}, 4'b0001);
        sb_push(ack);
        @(posedge clk);
        #1;
        chk("rel_vld", {31'h0, vld}, 1);
        @(negedge clk);
        chk("rel_ack1", {28'h0, ack}, 4'b0010);
        sb_check();
        req = '0;
        @(posedge clk);
        #1;

        // Out-of-range select on a 3-channel instance never grants.
        mode3 = 1'b0;
        sel3  = 2'd3;
        req3  = 3'b111;
        rdy3  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("oor_ack", {29'h0, ack3}, 0);
            @(posedge clk);
            #1;
            chk("oor_vld", {31'h0, vld3}, 0);
        end
        sel3 = 2'd1;
        @(negedge clk);
        chk("n3_ack", {29'h0, ack3}, 3'b010);
        @(posedge clk);
        #1;
        chk("n3_vld", {31'h0, vld3}, 1);
        chk("n3_y", {24'h0, y3}, 8'h22);
        chk("n3_gid", {30'h0, gid3}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
